revelador_tablero: RTL and testbench

REVELADOR_TABLERO -- requirements
Module: revelador_tablero

---
 rtl/revelador_tablero_if.sv | 27 ++
 rtl/revelador_tablero.sv | 172 +++++++++++++++++
 tb/tb_revelador_tablero.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/revelador_tablero_if.sv
// rtl/revelador_tablero_if.sv - board-reveal request/write-back bus
interface revelador_tablero_if;
    logic [7:0][7:0][6:0] tablero;
    logic                 iniciar;
    logic [2:0]           i_sel;
    logic [2:0]           j_sel;
    logic                 escribir;
    logic [2:0]           i_esc;
    logic [2:0]           j_esc;
    logic [6:0]           celda_esc;
    logic                 ocupado;
    logic                 listo;
    logic                 bomba_hallada;
    logic [6:0]           casillas_reveladas;

    modport master (
        output tablero, iniciar, i_sel, j_sel,
        input  escribir, i_esc, j_esc, celda_esc, ocupado, listo,
               bomba_hallada, casillas_reveladas
    );

    modport slave (
        input  tablero, iniciar, i_sel, j_sel,
        output escribir, i_esc, j_esc, celda_esc, ocupado, listo,
               bomba_hallada, casillas_reveladas
    );
endinterface

// File: rtl/revelador_tablero.sv
// rtl/revelador_tablero.sv - minesweeper cell reveal with raster flood-fill passes
module revelador_tablero (
    input  logic                 clk,
    input  logic                 rst,
    revelador_tablero_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, CARGA, SEL, BARRIDO, FIN} estado_t;

    localparam logic [63:0] COL0 = 64'h0101010101010101;
    localparam logic [63:0] COL7 = 64'h8080808080808080;

    estado_t              r_estado, w_estado;
    logic [7:0][7:0][6:0] r_board, w_board;
    logic [63:0]          r_mask, w_mask;
    logic [2:0]           r_i, w_i, r_j, w_j;
    logic                 r_cambio, w_cambio;
    logic                 r_escribir, w_escribir;
    logic [2:0]           r_i_esc, w_i_esc, r_j_esc, w_j_esc;
    logic [6:0]           r_celda_esc, w_celda_esc;
    logic                 r_ocupado, w_ocupado;
    logic                 r_listo, w_listo;
    logic                 r_bomba, w_bomba;
    logic [6:0]           r_cuenta, w_cuenta;

    logic [63:0]          w_mask_carga;
    logic [63:0]          w_abierto;
    logic [63:0]          w_vecino;
    logic [6:0]           w_celda;
    logic [5:0]           w_idx;
    logic                 w_revela;

    // Bit i*8+j of every 64-bit vector is cell (i,j); w_abierto marks revealed empty cells
    for (genvar gi = 0; gi < 8; gi++) begin : g_fila
        for (genvar gj = 0; gj < 8; gj++) begin : g_col
            assign w_mask_carga[gi*8+gj] = bus.tablero[gi][gj][5];
            assign w_abierto[gi*8+gj]    = r_mask[gi*8+gj] & ~r_board[gi][gj][6]
                                         & (r_board[gi][gj][3:0] == 4'd0);
        end
    end

    // Shifted copies bring each neighbour onto its cell; column masks stop j=7 <-> j=0 wrap
    assign w_vecino = ((w_abierto >> 1) & ~COL7) | ((w_abierto << 1) & ~COL0)
                    |  (w_abierto >> 8)          |  (w_abierto << 8)
                    | ((w_abierto >> 9) & ~COL7) | ((w_abierto >> 7) & ~COL0)
                    | ((w_abierto << 7) & ~COL7) | ((w_abierto << 9) & ~COL0);

    assign w_idx    = {r_i, r_j};
    assign w_celda  = r_board[r_i][r_j];
    assign w_revela = ~r_mask[w_idx] & ~w_celda[6] & ~w_celda[4] & w_vecino[w_idx];

    always_comb begin
        w_estado    = r_estado;
        w_board     = r_board;
        w_mask      = r_mask;
        w_i         = r_i;
        w_j         = r_j;
        w_cambio    = r_cambio;
        w_escribir  = 1'b0;
        w_i_esc     = r_i_esc;
        w_j_esc     = r_j_esc;
        w_celda_esc = r_celda_esc;
        w_bomba     = r_bomba;
        w_cuenta    = r_cuenta;
        case (r_estado)
            IDLE: begin
                if (bus.iniciar) begin
                    w_i      = bus.i_sel;
                    w_j      = bus.j_sel;
                    w_cuenta = 7'd0;
                    w_bomba  = 1'b0;
                    w_estado = CARGA;
                end
            end
            CARGA: begin
                w_board  = bus.tablero;
                w_mask   = w_mask_carga;
                w_estado = SEL;
            end
            SEL: begin
                if (w_celda[4] | w_celda[5]) begin
                    w_estado = FIN;
                end else begin
                    w_escribir  = 1'b1;
                    w_i_esc     = r_i;
                    w_j_esc     = r_j;
                    w_celda_esc = w_celda | 7'h20;
                    w_cuenta    = r_cuenta + 7'd1;
                    if (w_celda[6]) begin
                        w_bomba  = 1'b1;
                        w_estado = FIN;
                    end else begin
                        w_mask = r_mask | (64'd1 << w_idx);
                        if (w_celda[3:0] != 4'd0) begin
                            w_estado = FIN;
                        end else begin
                            w_i      = 3'd0;
                            w_j      = 3'd0;
                            w_cambio = 1'b0;
                            w_estado = BARRIDO;
                        end
                    end
                end
            end
            BARRIDO: begin
                if (w_revela) begin
                    w_escribir  = 1'b1;
                    w_i_esc     = r_i;
                    w_j_esc     = r_j;
                    w_celda_esc = w_celda | 7'h20;
                    w_cuenta    = r_cuenta + 7'd1;
                    w_mask      = r_mask | (64'd1 << w_idx);
                    w_cambio    = 1'b1;
                end
                {w_i, w_j} = w_idx + 6'd1;
                if (w_idx == 6'd63) begin
                    if (r_cambio | w_revela) begin
                        w_cambio = 1'b0;
                    end else begin
                        w_estado = FIN;
                    end
                end
            end
            FIN:     w_estado = IDLE;
            default: w_estado = IDLE;
        endcase
        w_listo   = (w_estado == FIN);
        w_ocupado = (w_estado != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado    <= IDLE;
            r_board     <= '0;
            r_mask      <= '0;
            r_i         <= 3'd0;
            r_j         <= 3'd0;
            r_cambio    <= 1'b0;
            r_escribir  <= 1'b0;
            r_i_esc     <= 3'd0;
            r_j_esc     <= 3'd0;
            r_celda_esc <= 7'd0;
            r_ocupado   <= 1'b0;
            r_listo     <= 1'b0;
            r_bomba     <= 1'b0;
            r_cuenta    <= 7'd0;
        end else begin
            r_estado    <= w_estado;
            r_board     <= w_board;
            r_mask      <= w_mask;
            r_i         <= w_i;
            r_j         <= w_j;
            r_cambio    <= w_cambio;
            r_escribir  <= w_escribir;
            r_i_esc     <= w_i_esc;
            r_j_esc     <= w_j_esc;
            r_celda_esc <= w_celda_esc;
            r_ocupado   <= w_ocupado;
            r_listo     <= w_listo;
            r_bomba     <= w_bomba;
            r_cuenta    <= w_cuenta;
        end
    end

    assign bus.escribir           = r_escribir;
    assign bus.i_esc              = r_i_esc;
    assign bus.j_esc              = r_j_esc;
    assign bus.celda_esc          = r_celda_esc;
    assign bus.ocupado            = r_ocupado;
    assign bus.listo              = r_listo;
    assign bus.bomba_hallada      = r_bomba;
    assign bus.casillas_reveladas = r_cuenta;
endmodule

// File: tb/tb_revelador_tablero.sv
// tb/tb_revelador_tablero.sv - directed self-checking bench for revelador_tablero
module tb_revelador_tablero;
    logic clk = 1'b0;
    logic rst = 1'b0;

    revelador_tablero_if bus ();

    revelador_tablero dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int e      = 0;
    int lat    = -1;
    int n_esc, n_dup, n_bomb, n_listo;
    int wcnt [64];
    logic [6:0] warr [64];
    logic [2:0] last_i, last_j;
    logic [6:0] last_celda;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.escribir) begin
            int k;
            k = int'({bus.i_esc, bus.j_esc});
            n_esc++;
            if (wcnt[k] != 0) n_dup++;
            wcnt[k]++;
            warr[k]    = bus.celda_esc;
            last_i     = bus.i_esc;
            last_j     = bus.j_esc;
            last_celda = bus.celda_esc;
            if (bus.celda_esc[6]) n_bomb++;
        end
        if (bus.listo) begin
            n_listo++;
            lat = cyc - e;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic limpiar();
        n_esc = 0; n_dup = 0; n_bomb = 0; n_listo = 0; lat = -1;
        for (int k = 0; k < 64; k++) begin
            wcnt[k] = 0;
            warr[k] = 7'd0;
        end
    endtask

    task automatic check_set(input string tag, input logic [63:0] esperado);
        int err;
        err = 0;
        for (int k = 0; k < 64; k++)
            if ((wcnt[k] != 0) != esperado[k]) err++;
        check(tag, err, 0);
    endtask

    function automatic logic [7:0][7:0][6:0] tablero_con(input logic [63:0] b);
        logic [7:0][7:0][6:0] t;
        int n;
        t = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                n = 0;
                if (b[i*8+j]) t[i][j] = 7'h40;
                else begin
                    for (int di = -1; di <= 1; di++)
                        for (int dj = -1; dj <= 1; dj++)
                            if ((di != 0 || dj != 0) && i+di >= 0 && i+di < 8 &&
                                j+dj >= 0 && j+dj < 8 && b[(i+di)*8+(j+dj)]) n++;
                    t[i][j] = {3'b000, 4'(n)};
                end
            end
        return t;
    endfunction

    // Called #1 after a rising edge; that next edge is edge E
    task automatic operar(input logic [7:0][7:0][6:0] b, input logic [2:0] i,
                          input logic [2:0] j, input int pulso);
        limpiar();
        bus.tablero = b;
        bus.i_sel   = i;
        bus.j_sel   = j;
        bus.iniciar = 1'b1;
        e = cyc + 1;
        @(posedge clk); #1 bus.iniciar = 1'b0;
        @(posedge clk); #1 bus.tablero = '1;
        if (pulso > 0) begin
            repeat (pulso) @(posedge clk);
            #1 bus.iniciar = 1'b1; bus.i_sel = 3'd5; bus.j_sel = 3'd5;
            @(posedge clk); #1 bus.iniciar = 1'b0;
        end
        for (int k = 0; k < 400 && n_listo == 0; k++) begin
            @(negedge clk); #1;
        end
        check("listo_seen", n_listo, 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic siguiente();
        @(posedge clk); #1;
    endtask

    logic [7:0][7:0][6:0] b;
    int s;

    initial begin
        bus.tablero = '0; bus.iniciar = 1'b0; bus.i_sel = 3'd0; bus.j_sel = 3'd0;
        limpiar();
        repeat (3) @(posedge clk);
        #1;
        check("rst_escribir", bus.escribir, 0);
        check("rst_ocupado", bus.ocupado, 0);
        check("rst_listo", bus.listo, 0);
        check("rst_bomba", bus.bomba_hallada, 0);
        check("rst_casillas", bus.casillas_reveladas, 0);
        check("rst_i_esc", bus.i_esc, 0);
        check("rst_j_esc", bus.j_esc, 0);
        check("rst_celda", bus.celda_esc, 0);

        // numbered cell, started on the first edge after reset release
        rst = 1'b1;
        b = '0; b[3][4] = 7'h02;
        operar(b, 3'd3, 3'd4, 0);
        check("num_writes", n_esc, 1);
        check("num_i", last_i, 3);
        check("num_j", last_j, 4);
        check("num_celda", last_celda, 7'h22);
        check("num_lat", lat, 2);
        check("num_casillas", bus.casillas_reveladas, 1);
        check("num_bomba", bus.bomba_hallada, 0);
        check("num_ocupado", bus.ocupado, 0);

        siguiente();
        b = '0; b[6][5] = 7'h40;
        operar(b, 3'd6, 3'd5, 0);
        check("bomb_writes", n_esc, 1);
        check("bomb_i", last_i, 6);
        check("bomb_j", last_j, 5);
        check("bomb_celda", last_celda, 7'h60);
        check("bomb_flag", bus.bomba_hallada, 1);
        check("bomb_casillas", bus.casillas_reveladas, 1);

        siguiente();
        b = '0; b[2][2] = 7'h10;
        operar(b, 3'd2, 3'd2, 0);
        check("flag_writes", n_esc, 0);
        check("flag_casillas", bus.casillas_reveladas, 0);
        check("flag_bomba_clr", bus.bomba_hallada, 0);

        siguiente();
        b = '0; b[5][1] = 7'h23;
        operar(b, 3'd5, 3'd1, 0);
        check("rev_writes", n_esc, 0);
        check("rev_casillas", bus.casillas_reveladas, 0);

        siguiente();
        operar('0, 3'd0, 3'd0, 0);
        check("zero_writes", n_esc, 64);
        check("zero_dups", n_dup, 0);
        check("zero_lat", lat, 130);
        check("zero_casillas", bus.casillas_reveladas, 64);
        check("zero_celda77", warr[63], 7'h20);

        siguiente();
        operar(tablero_con(64'h0100000000000080), 3'd0, 3'd0, 0);
        check("corner_writes", n_esc, 62);
        check("corner_dups", n_dup, 0);
        check("corner_bombs", n_bomb, 0);
        check_set("corner_set", ~64'h0100000000000080);
        check("corner_celda16", warr[14], 7'h21);
        check("corner_casillas", bus.casillas_reveladas, 62);

        // bomb wall on column 6: column 7 must stay hidden unless edges wrap
        siguiente();
        operar(tablero_con(64'h4040404040404040), 3'd0, 3'd0, 0);
        check("wall_writes", n_esc, 48);
        check_set("wall_set", 64'h3F3F3F3F3F3F3F3F);
        check("wall_casillas", bus.casillas_reveladas, 48);

        siguiente();
        limpiar();
        bus.tablero = '0; bus.i_sel = 3'd0; bus.j_sel = 3'd0; bus.iniciar = 1'b1;
        e = cyc + 1;
        @(posedge clk); #1 bus.iniciar = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort_escribir", bus.escribir, 0);
        check("abort_ocupado", bus.ocupado, 0);
        check("abort_casillas", bus.casillas_reveladas, 0);
        s = n_esc;
        repeat (4) @(negedge clk);
        #1;
        check("abort_no_writes", n_esc, s);
        check("abort_no_listo", n_listo, 0);
        @(posedge clk); #1 rst = 1'b1;
        operar('0, 3'd0, 3'd0, 50);
        check("after_writes", n_esc, 64);
        check("after_lat", lat, 130);
        check("after_casillas", bus.casillas_reveladas, 64);
        check("after_dups", n_dup, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
